// File: rtl/sreg_in_pkg.sv
// Shared definitions for the serial-to-parallel receiver.
// These definitions take the place of the old sreg_defs.vh include.
package sreg_in_pkg;

    // Flop stages in each input synchroniser.
    localparam int unsigned SYNC_STAGES = 2;

    // Receiver control states. The encodings match the original SR_* values.
    typedef enum logic [1:0] {
        SR_IDLE  = 2'd0,
        SR_SHIFT = 2'd1,
        SR_PUSH  = 2'd2
    } sr_state_e;

endpackage

// File: rtl/sreg_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input.
// It can also produce a one-clock pulse on a rising edge of the synchronised signal.
module sreg_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter bit          RST_VAL = 1'b0,
    parameter bit          EDGE_EN = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchroniser chain, plus a delayed copy of its output for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = EDGE_EN ? (q_o & ~prev_q) : 1'b0;

endmodule

// File: rtl/sreg_in.sv
// Serial-to-parallel receiver with a small first-word-fall-through output FIFO.
// It assembles WIDTH-bit words from sdata, clocked by sclk and framed by frame_n.
// Each completed word is pushed into the FIFO.
// The FIFO reports empty (isr), sticky overrun and sticky framing errors.
module sreg_in
    import sreg_in_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sdata,
    input  logic             sclk,
    input  logic             frame_n,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             isr,
    output logic [2:0]       level,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [2:0]       FULL_LVL = 3'(DEPTH);

    // ------------------------------------------------------------------
    // Input synchronisers. All three inputs use the same delay, so data and frame stay aligned with the sclk edge pulse.
    // ------------------------------------------------------------------
    logic sdata_s, frame_n_s, sclk_s, sclk_rise;
    logic sdata_rise_unused, frame_rise_unused, sclk_s_unused;

    sreg_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_sdata (
        .clk_i (clock),
        .rst_ni(reset_n),
        .d_i   (sdata),
        .q_o   (sdata_s),
        .rise_o(sdata_rise_unused)
    );

    sreg_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sclk (
        .clk_i (clock),
        .rst_ni(reset_n),
        .d_i   (sclk),
        .q_o   (sclk_s),
        .rise_o(sclk_rise)
    );

    sreg_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_EN(1'b0)) u_sync_frame (
        .clk_i (clock),
        .rst_ni(reset_n),
        .d_i   (frame_n),
        .q_o   (frame_n_s),
        .rise_o(frame_rise_unused)
    );

    assign sclk_s_unused = sclk_s;

    // ------------------------------------------------------------------
    // Receive state machine: bit counter and shift register
    // ------------------------------------------------------------------
    sr_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             push;
    logic             ferr_set;

    // State, bit count and shift register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SR_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic.
    // When the frame closes, that takes priority over a coincident sclk edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            SR_IDLE: begin
                cnt_d = '0;
                if (!frame_n_s) state_d = SR_SHIFT;
            end
            SR_SHIFT: begin
                if (frame_n_s) begin
                    state_d  = SR_IDLE;
                    ferr_set = (cnt_q != '0);
                    cnt_d    = '0;
                end else if (sclk_rise) begin
                    if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], sdata_s};
                    else           shift_d = {sdata_s, shift_q[WIDTH-1:1]};
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = SR_PUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SR_PUSH: begin
                push    = 1'b1;
                state_d = frame_n_s ? SR_IDLE : SR_SHIFT;
            end
            default: state_d = SR_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0]       lvl_q, lvl_d;
    logic             full, pop, wr_en, ovr_set;
    logic             overrun_q, overrun_d, ferr_q, ferr_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (lvl_q == FULL_LVL);
    assign rd_valid = (lvl_q != '0);
    assign pop      = rd_valid & rd_ready;
    // A push into a full FIFO still fits when the same cycle frees a slot.
    assign wr_en    = push & (~full | pop);
    assign ovr_set  = push & full & ~pop;

    // Next occupancy and sticky flags. A new error takes priority over clr_err.
    always_comb begin
        lvl_d = lvl_q;
        case ({wr_en, pop})
            2'b10:   lvl_d = lvl_q + 3'd1;
            2'b01:   lvl_d = lvl_q - 3'd1;
            default: lvl_d = lvl_q;
        endcase
        overrun_d = (overrun_q & ~clr_err) | ovr_set;
        ferr_d    = (ferr_q & ~clr_err) | ferr_set;
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            lvl_q     <= '0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
            lvl_q     <= lvl_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    // FIFO storage. It is reset so that rd_data reads zero while in reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign isr       = ~rd_valid;
    assign level     = lvl_q;
    assign overrun   = overrun_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_sreg_in.sv
// Directed bench for sreg_in.
// The main instance uses the defaults: 32-bit words, depth 2, MSB first.
// A second instance uses 8-bit words, LSB first, and shares the serial inputs.
module tb_sreg_in;

    logic        clock = 1'b0;
    logic        reset_n, sdata, sclk, frame_n, rd_ready, clr_err, rd_ready8;
    logic [31:0] rd_data;
    logic        rd_valid, isr, overrun, frame_err;
    logic [2:0]  level;
    logic [7:0]  rd_data8;
    logic        rd_valid8, isr8, overrun8, frame_err8;
    logic [2:0]  level8;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    sreg_in #(.WIDTH(32), .DEPTH(2), .MSB_FIRST(1'b1)) u_dut (
        .clock(clock), .reset_n(reset_n), .sdata(sdata), .sclk(sclk), .frame_n(frame_n),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .isr(isr),
        .level(level), .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err)
    );

    sreg_in #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b0)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .sdata(sdata), .sclk(sclk), .frame_n(frame_n),
        .rd_data(rd_data8), .rd_valid(rd_valid8), .rd_ready(rd_ready8), .isr(isr8),
        .level(level8), .overrun(overrun8), .frame_err(frame_err8), .clr_err(clr_err)
    );

    typedef struct {
        logic [31:0] data;
        int          nbits;     // 0: no serial traffic, just check
        bit          close;     // raise frame_n after the bits
        int          pops;      // pops after the checks
        bit          clr;       // clr_err pulse after the pops
        logic [2:0]  exp_level;
        bit          exp_valid;
        logic [31:0] exp_data;
        bit          exp_ovr;
        bit          exp_ferr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One bit: sclk is low for 4 clocks, then high for 4 clocks.
    // mode 1 checks rd_valid latency after the rising edge.
    // mode 2 asserts rd_ready for exactly the FIFO push cycle.
    task automatic send_bit(input logic b, input int mode);
        sdata = b;
        sclk  = 1'b0;
        tick(4);
        sclk = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            if (mode == 1) chk($sformatf("latency_valid_k%0d", k), 32'(rd_valid), 32'(k == 4));
            if (mode == 2 && k == 3) rd_ready = 1'b1;
            if (mode == 2 && k == 4) rd_ready = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits, input int last_mode);
        for (int i = nbits - 1; i >= 0; i--) send_bit(w[i], (i == 0) ? last_mode : 0);
    endtask

    task automatic open_frame();
        frame_n = 1'b0;
        tick(4);
    endtask

    task automatic close_frame();
        frame_n = 1'b1;
        tick(4);
    endtask

    task automatic do_pop();
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        tick(1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
        chk({tag, "_isr"},       32'(isr),       32'd1);
        chk({tag, "_level"},     32'(level),     32'd0);
        chk({tag, "_overrun"},   32'(overrun),   32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_rd_data"},   rd_data,        32'd0);
        chk({tag, "_rd_valid8"}, 32'(rd_valid8), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; sdata = 1'b0; sclk = 1'b0; frame_n = 1'b1;
        rd_ready = 1'b0; clr_err = 1'b0; rd_ready8 = 1'b0;

        //            data          nb  cl pop clr lvl   v     exp_data      ovr   ferr
        vecs[0] = '{32'hA5C30F81, 32, 1'b1, 1, 1'b0, 3'd1, 1'b1, 32'hA5C30F81, 1'b0, 1'b0};
        vecs[1] = '{32'h00000000,  0, 1'b0, 0, 1'b0, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[2] = '{32'h11111111, 32, 1'b0, 0, 1'b0, 3'd1, 1'b1, 32'h11111111, 1'b0, 1'b0};
        vecs[3] = '{32'h22222222, 32, 1'b0, 0, 1'b0, 3'd2, 1'b1, 32'h11111111, 1'b0, 1'b0};
        vecs[4] = '{32'h33333333, 32, 1'b1, 1, 1'b0, 3'd2, 1'b1, 32'h11111111, 1'b1, 1'b0};
        vecs[5] = '{32'h00000000,  0, 1'b0, 1, 1'b1, 3'd1, 1'b1, 32'h22222222, 1'b1, 1'b0};
        vecs[6] = '{32'h00000000,  0, 1'b0, 0, 1'b0, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b0};
        vecs[7] = '{32'h00000ABC, 12, 1'b1, 0, 1'b0, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b1};
        vecs[8] = '{32'hDEADBEEF, 32, 1'b1, 1, 1'b1, 3'd1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
        vecs[9] = '{32'h00000000,  0, 1'b0, 0, 1'b0, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b0};

        tick(2);
        chk_reset_outputs("init_reset");
        reset_n = 1'b1;
        tick(2);

        // Table-driven sequences: single word, overrun, framing error, clr_err.
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].nbits > 0) begin
                if (frame_n) open_frame();
                send_word(vecs[v].data, vecs[v].nbits, 0);
                if (vecs[v].close) close_frame();
            end else begin
                tick(2);
            end
            chk($sformatf("v%0d_level", v),     32'(level),     32'(vecs[v].exp_level));
            chk($sformatf("v%0d_rd_valid", v),  32'(rd_valid),  32'(vecs[v].exp_valid));
            chk($sformatf("v%0d_isr", v),       32'(isr),       32'(!vecs[v].exp_valid));
            chk($sformatf("v%0d_overrun", v),   32'(overrun),   32'(vecs[v].exp_ovr));
            chk($sformatf("v%0d_frame_err", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
            if (vecs[v].exp_valid) chk($sformatf("v%0d_rd_data", v), rd_data, vecs[v].exp_data);
            repeat (vecs[v].pops) do_pop();
            if (vecs[v].clr) pulse_clr();
        end

        // Latency: rd_valid rises at the 4th negedge after the last sclk rise.
        open_frame();
        send_word(32'hA5C30F81, 32, 1);
        close_frame();
        chk("lat_rd_data", rd_data, 32'hA5C30F81);
        chk("lat_level", 32'(level), 32'd1);
        do_pop();
        chk("lat_pop_valid", 32'(rd_valid), 32'd0);
        chk("lat_pop_isr", 32'(isr), 32'd1);

        // Push and pop in the same cycle while the FIFO is full.
        open_frame();
        send_word(32'h00000001, 32, 0);
        send_word(32'h00000002, 32, 0);
        send_word(32'h00000003, 32, 2);
        close_frame();
        chk("pp_overrun", 32'(overrun), 32'd0);
        chk("pp_level", 32'(level), 32'd2);
        chk("pp_head0", rd_data, 32'h00000002);
        do_pop();
        chk("pp_head1", rd_data, 32'h00000003);
        do_pop();
        chk("pp_level_end", 32'(level), 32'd0);

        // Reset in the middle of a word, with a word already in the FIFO.
        open_frame();
        send_word(32'hCAFEF00D, 32, 0);
        send_word(32'h00012345, 20, 0);
        chk("rst_pre_level", 32'(level), 32'd1);
        reset_n = 1'b0;
        sclk    = 1'b0;
        sdata   = 1'b0;
        tick(2);
        chk_reset_outputs("mid_reset");
        reset_n = 1'b1;
        tick(4);
        send_word(32'h0000FFFF, 32, 0);
        close_frame();
        chk("post_rst_rd_data", rd_data, 32'h0000FFFF);
        chk("post_rst_level", 32'(level), 32'd1);
        chk("post_rst_frame_err", 32'(frame_err), 32'd0);
        do_pop();

        // LSB-first 8-bit instance.
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        open_frame();
        send_word(32'h00000080, 8, 0);   // bits 1,0,0,0,0,0,0,0
        send_word(32'h000000A3, 8, 0);   // bits 1,0,1,0,0,0,1,1
        close_frame();
        chk("w8_level", 32'(level8), 32'd2);
        chk("w8_head0", 32'(rd_data8), 32'h01);
        chk("w8_overrun", 32'(overrun8), 32'd0);
        chk("w8_frame_err", 32'(frame_err8), 32'd0);
        rd_ready8 = 1'b1;
        tick(1);
        rd_ready8 = 1'b0;
        tick(1);
        chk("w8_head1", 32'(rd_data8), 32'hC5);
        chk("w8_level_after", 32'(level8), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sreg_in.md
Name: sreg_in

Overview:
- Serial-to-parallel receiver: the downstream counterpart of the 32-bit shift-out stage.
- Samples a serial bit stream (sdata, qualified by an external shift clock sclk and an active-low frame enable frame_n) and assembles WIDTH-bit words.
- Pushes each completed word into a small first-word-fall-through (FWFT) FIFO, which the CPU/DMA side reads through a valid/ready handshake.
- Reports FIFO empty as an interrupt source, plus sticky overrun and framing errors.

Parameters:
- WIDTH, 32, word length in bits (8..32).
- DEPTH, 2, FIFO depth in words (2 or 4).
- MSB_FIRST, 1, 1 = first received bit lands in bit WIDTH-1; 0 = first bit lands in bit 0.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- sdata  in  1  serial data, asynchronous to clock.
- sclk  in  1  external shift clock, asynchronous; data sampled on its rising edge.
- frame_n  in  1  frame enable, asynchronous, active low.
- rd_data  out  WIDTH  head-of-FIFO word; meaningful only while rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer accepts rd_data; pop occurs when rd_valid & rd_ready.
- isr  out  1  FIFO empty (= ~rd_valid).
- level  out  3  FIFO occupancy, 0..DEPTH.
- overrun  out  1  sticky: a word was dropped because the FIFO was full.
- frame_err  out  1  sticky: frame closed mid-word.
- clr_err  in  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset: asynchronous, active-low, one clock. Every reset is async assert; release is synchronised by the system.
- Values while reset_n=0: state=IDLE, bit count=0, shift register=0, FIFO empty, rd_valid=0, isr=1, level=0, overrun=0, frame_err=0, rd_data=0.
- Synchronisers: sdata, sclk and frame_n each pass through 2 flops, all with the same delay.
  - sclk edge pulse: edge = sclk_s & ~sclk_d, one clock wide.
  - Sampling: sdata_s is sampled in the cycle where edge=1.
  - Rate limit: sclk high and low times must each be at least 2 clocks; faster input is out of spec.
- States:
  - IDLE: frame_n_s=1. Edges are ignored; count held at 0. Goes to SHIFT when frame_n_s=0.
  - SHIFT: on each edge, shift the bit in and increment count.
    - Edge with count=WIDTH-1: goes to PUSH and count returns to 0.
    - frame_n_s=1 with count=0: goes to IDLE, no error.
    - frame_n_s=1 with count in 1..WIDTH-1: partial word discarded, frame_err set, goes to IDLE.
  - PUSH: exactly one cycle; writes the shift register to the FIFO.
    - Next state is SHIFT if frame_n_s=0, else IDLE.
    - An edge arriving during PUSH cannot occur at spec rate, so it is ignored.
- Latency: the last bit's edge in cycle N gives FIFO write at the end of N+1, and rd_valid=1 at N+2 if the FIFO was empty.
- FIFO (FWFT):
  - Push when not full: accepted, level+1.
  - Push when full with no pop: word dropped, overrun=1, level unchanged.
  - Push and pop in the same cycle when full: both take effect, level unchanged, no overrun.
  - Push and pop in the same cycle when empty: impossible, since rd_valid=0.
  - Pop when empty: no effect.
  - Pointers wrap modulo DEPTH.
- Sticky flags: clr_err takes priority over a set event in the same cycle only for the flag's previous value. A new error in the clr_err cycle still sets the flag (set wins).
- Bit order:
  - MSB_FIRST=1: shift left, new bit into bit 0.
  - MSB_FIRST=0: shift right, new bit into bit WIDTH-1.

Decomposition:
- sreg_defs.vh (shared include): state encodings SR_IDLE=2'd0, SR_SHIFT=2'd1, SR_PUSH=2'd2; synchroniser depth constant SYNC_STAGES=2.
- One sub-module, sreg_sync_edge: 2-flop synchroniser with optional rising-edge pulse output. Instantiated three times.
- The FIFO stays inline.

Test Plan:
- Single word: frame_n low; send 0xA5C30F81 MSB-first with 4-clock sclk half-periods; frame_n high.
  -> rd_valid rises 2 clocks after the 32nd edge pulse, rd_data=0xA5C30F81, level=1, isr=0. A pop then gives rd_valid=0, isr=1.
- Overrun, DEPTH=2, rd_ready=0: send 0x11111111, 0x22222222, 0x33333333 in one frame.
  -> level=2, overrun=1, rd_data=0x11111111. A pop gives rd_data=0x22222222.
- Frame error: send 12 bits then frame_n high -> frame_err=1, level=0. Next full word 0xDEADBEEF is received intact. clr_err then gives frame_err=0.
- Simultaneous push/pop at full, DEPTH=2: FIFO holds 1 and 2; 3rd word's push cycle coincides with rd_ready=1.
  -> overrun=0, level=2, contents 2 then 3.
- Reset mid-word: assert reset_n=0 after 20 bits, release, send 0x0000FFFF.
  -> all outputs at reset values during reset; next read returns 0x0000FFFF exactly.
- MSB_FIRST=0, WIDTH=8: send bit sequence 1,0,0,0,0,0,0,0 -> rd_data=8'h01.
